uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter; the transmit side of the link served by the UART receiver.
//   Serialises one byte per frame: 8N1, LSB first (start bit, 8 data bits, 1 stop bit,
//   no parity).
//   Has a one-byte holding register, so the host can queue the next byte while the
//   current frame shifts out. Sits between the sensor/command logic and the TX pin.
// PARAMETERS
//   CLOCKS_PER_BIT  87  clock cycles per UART bit = f_clock / baud (e.g. 10 MHz / 115200); must be >= 2
// PORTS
//   clock            in   1  system clock; all logic on rising edge
//   reset            in   1  synchronous, active-high reset
//   send             in   1  host requests transmission of data_to_send
//   data_to_send     in   8  byte to transmit; sampled only on acceptance
//   ready            out  1  holding register empty; a byte can be accepted
//   outgoing_bit     out  1  serial TX line, idle high; registered output
//   is_transmitting  out  1  high while a frame (start..stop) is on the line
//   done             out  1  one-cycle pulse on the last clock of each stop bit
// BEHAVIOUR
//   Reset (sampled at a clock edge, overrides everything):
//     outgoing_bit=1, is_transmitting=0, done=0, ready=1, holding empty,
//     state=IDLE, bit counter=0, bit index=0.
//     Reset mid-frame aborts the frame; the line returns high on the reset edge.
//   Acceptance:
//     - Byte accepted at an edge where send=1 and ready=1; data_to_send latched
//       into the holding register; ready=0 from the next cycle.
//     - send while ready=0 is ignored (no error, no overwrite).
//     - ready = !holding_full; no combinational path from send to ready.
//   Timing:
//     - Bit counter width $clog2(CLOCKS_PER_BIT); counts 0..CLOCKS_PER_BIT-1 per bit.
//     - Each bit is held on outgoing_bit for exactly CLOCKS_PER_BIT cycles.
//     - Full frame = 10*CLOCKS_PER_BIT cycles.
//   FSM states:
//     IDLE:      outgoing_bit=1, is_transmitting=0. If holding full: move holding to
//                the shift register, empty holding (ready=1 next cycle), drive
//                outgoing_bit=0, go to START_BIT, counter=0.
//     START_BIT: outgoing_bit=0. At counter==CLOCKS_PER_BIT-1: drive shift[0],
//                index=0, go to DATA_BITS.
//     DATA_BITS: outgoing_bit=shift[index]. At counter==CLOCKS_PER_BIT-1: if index
//                is not 7, index+1 and drive the next bit; else drive 1 and go to
//                STOP_BIT.
//     STOP_BIT:  outgoing_bit=1. At counter==CLOCKS_PER_BIT-1: done=1 for this cycle.
//                If holding full, load the next byte and go directly to START_BIT
//                (no idle gap, back-to-back frames); else go to IDLE.
//     Undefined state encodings go to IDLE with outgoing_bit=1.
//   Latency:
//     - Accept at edge E0 gives outgoing_bit=0 from edge E1 (from IDLE, holding
//       path).
//     - First start bit is therefore on the line 1 cycle after acceptance.
//   Simultaneous events:
//     - Holding drained (load into shift) in the same cycle as send: the byte is not
//       accepted (ready was 0).
//     - The host must wait for ready=1.
//   is_transmitting=1 for every cycle outgoing_bit is driven by START/DATA/STOP.
// TESTING (bench uses CLOCKS_PER_BIT=4; pair with the UART receiver in loopback where noted)
//   1. reset held 3 cycles -> outgoing_bit=1, ready=1, done=0, is_transmitting=0.
//   2. send 0xA5 once from idle -> line 0,1,0,1,0,0,1,0,1,1, each for 4 clocks;
//      start 1 cycle after accept; done pulses once at clock 40 of the frame.
//   3. send 0x3C, then 0xC3 as soon as ready rises -> two contiguous 40-cycle
//      frames, no idle gap; RX loopback reports 0x3C then 0xC3.
//   4. send 0x55 while holding is full (ready=0) -> ignored; only the queued bytes
//      appear on the line.
//   5. reset asserted at data bit 3 of 0xFF -> outgoing_bit=1 next edge; ready=1;
//      a following send of 0x81 produces one clean frame.
//   6. Loopback sweep of 0x00..0xFF through the receiver -> all 256 bytes received
//      intact; done count = 256.

Source files
------------

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - host handshake and serial line bundle for the UART transmitter
interface uart_tx_if;
    logic       send;
    logic [7:0] data_to_send;
    logic       ready;
    logic       outgoing_bit;
    logic       is_transmitting;
    logic       done;

    modport master (
        output send,
        output data_to_send,
        input  ready,
        input  outgoing_bit,
        input  is_transmitting,
        input  done
    );

    modport slave (
        input  send,
        input  data_to_send,
        output ready,
        output outgoing_bit,
        output is_transmitting,
        output done
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 LSB-first UART transmitter with a one-byte holding register
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 87
) (
    input  logic      clock,
    input  logic      reset,
    uart_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [2:0]       index, index_next, index_inc;
    logic [7:0]       shift, shift_next;
    logic [7:0]       holding;
    logic             holding_full;
    logic             line, line_next;
    logic             load;
    logic             accept;
    logic             bit_end;

    assign bit_end   = (counter == LAST_COUNT);
    assign accept    = bus.send && !holding_full;
    assign index_inc = index + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            index        <= 3'd0;
            shift        <= 8'h00;
            holding      <= 8'h00;
            holding_full <= 1'b0;
            line         <= 1'b1;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            index   <= index_next;
            shift   <= shift_next;
            line    <= line_next;
            // accept and load are mutually exclusive: one needs holding empty, the other full
            if (accept) begin
                holding      <= bus.data_to_send;
                holding_full <= 1'b1;
            end else if (load) begin
                holding_full <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter + 1'b1;
        index_next   = index;
        shift_next   = shift;
        line_next    = line;
        load         = 1'b0;
        case (state)
            IDLE: begin
                counter_next = '0;
                line_next    = 1'b1;
                if (holding_full) begin
                    load       = 1'b1;
                    shift_next = holding;
                    line_next  = 1'b0;
                    state_next = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    counter_next = '0;
                    index_next   = 3'd0;
                    line_next    = shift[0];
                    state_next   = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    counter_next = '0;
                    if (index != 3'd7) begin
                        index_next = index_inc;
                        line_next  = shift[index_inc];
                    end else begin
                        line_next  = 1'b1;
                        state_next = STOP_BIT;
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    counter_next = '0;
                    // a queued byte starts its start bit right after this stop bit
                    if (holding_full) begin
                        load       = 1'b1;
                        shift_next = holding;
                        line_next  = 1'b0;
                        state_next = START_BIT;
                    end else begin
                        line_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                counter_next = '0;
                line_next    = 1'b1;
                state_next   = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.ready           = !holding_full;
        bus.outgoing_bit    = line;
        bus.is_transmitting = (state != IDLE);
        bus.done            = (state == STOP_BIT) && bit_end;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx at 4 clocks per bit
module tb_uart_tx;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   done_count;

    uart_tx_if bus ();

    uart_tx #(.CLOCKS_PER_BIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string name);
        tick();
        n_cmp++;
        if (bus.outgoing_bit !== 1'b1) begin
            n_err++; $display("FAIL %s idle line got=%b want=1", name, bus.outgoing_bit);
        end
        n_cmp++;
        if (bus.is_transmitting !== 1'b0) begin
            n_err++; $display("FAIL %s idle is_transmitting got=%b want=0", name, bus.is_transmitting);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++; $display("FAIL %s idle done got=%b want=0", name, bus.done);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.send = 1'b1;
        bus.data_to_send = b;
        tick();
        bus.send = 1'b0;
        n_cmp++;
        if (bus.ready !== 1'b0) begin
            n_err++; $display("FAIL accept %h ready got=%b want=0", b, bus.ready);
        end
        n_cmp++;
        if (bus.outgoing_bit !== 1'b1) begin
            n_err++; $display("FAIL accept %h line before start got=%b want=1", b, bus.outgoing_bit);
        end
    endtask

    // Frame must begin at the next edge; optionally queues qbyte or pokes a junk send.
    task automatic check_frame(input logic [7:0] b, input int queue_at, input logic [7:0] qbyte,
                               input int junk_at);
        logic [9:0] exp_bits;
        logic [7:0] rx;
        logic       exp_bit;
        exp_bits = {1'b1, b, 1'b0};
        rx = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_bit = exp_bits[(k - 1) / 4];
            n_cmp++;
            if (bus.outgoing_bit !== exp_bit) begin
                n_err++; $display("FAIL frame %h line cycle=%0d got=%b want=%b", b, k, bus.outgoing_bit, exp_bit);
            end
            n_cmp++;
            if (bus.done !== (k == 40)) begin
                n_err++; $display("FAIL frame %h done cycle=%0d got=%b want=%b", b, k, bus.done, (k == 40));
            end
            n_cmp++;
            if (bus.is_transmitting !== 1'b1) begin
                n_err++; $display("FAIL frame %h is_transmitting cycle=%0d got=%b want=1", b, k, bus.is_transmitting);
            end
            if (bus.done === 1'b1) done_count++;
            if (k > 4 && k <= 36 && ((k - 1) % 4) == 1) rx[(k - 5) / 4] = bus.outgoing_bit;
            if (queue_at > 0 && k == queue_at) begin
                n_cmp++;
                if (bus.ready !== 1'b1) begin
                    n_err++; $display("FAIL frame %h ready before queue cycle=%0d got=%b want=1", b, k, bus.ready);
                end
                bus.send = 1'b1;
                bus.data_to_send = qbyte;
            end
            if (queue_at > 0 && k == queue_at + 1) begin
                bus.send = 1'b0;
                n_cmp++;
                if (bus.ready !== 1'b0) begin
                    n_err++; $display("FAIL frame %h ready after queue got=%b want=0", b, bus.ready);
                end
            end
            if (junk_at > 0 && k == junk_at) begin
                bus.send = 1'b1;
                bus.data_to_send = 8'h55;
            end
            if (junk_at > 0 && k == junk_at + 1) begin
                bus.send = 1'b0;
                n_cmp++;
                if (bus.ready !== 1'b0) begin
                    n_err++; $display("FAIL frame %h ready after ignored send got=%b want=0", b, bus.ready);
                end
            end
        end
        n_cmp++;
        if (rx !== b) begin
            n_err++; $display("FAIL frame rx byte got=%h want=%h", rx, b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (bus.outgoing_bit !== 1'b1) begin n_err++; $display("FAIL reset line got=%b want=1", bus.outgoing_bit); end
        n_cmp++;
        if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset ready got=%b want=1", bus.ready); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done got=%b want=0", bus.done); end
        n_cmp++;
        if (bus.is_transmitting !== 1'b0) begin n_err++; $display("FAIL reset is_transmitting got=%b want=0", bus.is_transmitting); end
        reset = 1'b0;
        check_idle("post_reset");
    endtask

    task automatic test_single();
        send_byte(8'hA5);
        check_frame(8'hA5, 0, 8'h00, 0);
        check_idle("single");
    endtask

    task automatic test_back_to_back();
        send_byte(8'h3C);
        check_frame(8'h3C, 1, 8'hC3, 0);
        check_frame(8'hC3, 0, 8'h00, 0);
        check_idle("back_to_back");
    endtask

    task automatic test_ignored_send();
        send_byte(8'h12);
        check_frame(8'h12, 1, 8'h34, 10);
        check_frame(8'h34, 0, 8'h00, 0);
        check_idle("ignored_send");
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hFF);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) begin bus.send = 1'b1; bus.data_to_send = 8'h0F; end
            if (k == 2) bus.send = 1'b0;
        end
        n_cmp++;
        if (bus.is_transmitting !== 1'b1 || bus.ready !== 1'b0) begin
            n_err++; $display("FAIL midframe pre-reset tx=%b ready=%b want tx=1 ready=0", bus.is_transmitting, bus.ready);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.outgoing_bit !== 1'b1) begin n_err++; $display("FAIL midframe reset line got=%b want=1", bus.outgoing_bit); end
        n_cmp++;
        if (bus.ready !== 1'b1) begin n_err++; $display("FAIL midframe reset ready got=%b want=1", bus.ready); end
        n_cmp++;
        if (bus.is_transmitting !== 1'b0) begin n_err++; $display("FAIL midframe reset is_transmitting got=%b want=0", bus.is_transmitting); end
        reset = 1'b0;
        check_idle("after_abort_1");
        check_idle("after_abort_2");
        check_idle("after_abort_3");
        send_byte(8'h81);
        check_frame(8'h81, 0, 8'h00, 0);
        check_idle("after_81");
    endtask

    task automatic test_sweep();
        int start_count;
        start_count = done_count;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            check_frame(8'(i), (i < 255) ? 1 : 0, 8'(i + 1), 0);
        end
        check_idle("sweep");
        n_cmp++;
        if (done_count - start_count !== 256) begin
            n_err++; $display("FAIL sweep done_count got=%0d want=256", done_count - start_count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        done_count = 0;
        reset = 1'b1;
        bus.send = 1'b0;
        bus.data_to_send = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_send();
        test_reset_mid_frame();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
